// File: rtl/ip_backward_ctrl.sv
// Issue/drain sequencer for a pipelined dot-product datapath: issues NUM_OUT rows, then retires their results.
// Optional id checking is compiled in with IP_BACKWARD_CTRL_ID_CHECK_EN.
module ip_backward_ctrl #(
  parameter int unsigned NUM_OUT = 16,
  parameter int unsigned LATENCY = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        hold,
  output logic        busy,
  output logic        done,
  output logic        issue,
  output logic [7:0]  row_idx,
  output logic [7:0]  dp_in_id,
  input  logic [31:0] dp_out_data,
  input  logic [7:0]  dp_out_id,
  output logic        res_valid,
  output logic [31:0] res_data,
  output logic [7:0]  res_idx,
  output logic        id_err
);

  localparam logic [8:0] LAST = 9'(NUM_OUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t        state_q, state_d;
  logic [8:0]    issue_cnt_q, issue_cnt_d;
  logic [8:0]    retire_cnt_q, retire_cnt_d;
  logic [LATENCY:0] vld_q, vld_d;
  logic [7:0]    last_row_q, last_row_d;
  logic [31:0]   res_data_q;
  logic [7:0]    res_idx_q;

  always_comb begin
    state_d      = state_q;
    issue_cnt_d  = issue_cnt_q;
    retire_cnt_d = retire_cnt_q;
    last_row_d   = last_row_q;
    issue        = 1'b0;
    if (res_valid) retire_cnt_d = retire_cnt_q + 9'd1;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d      = ISSUE;
          issue_cnt_d  = '0;
          retire_cnt_d = '0;
        end
      end
      ISSUE: begin
        issue = !hold;
        if (issue) begin
          last_row_d  = issue_cnt_q[7:0];
          issue_cnt_d = issue_cnt_q + 9'd1;
          if (issue_cnt_q == LAST) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (res_valid && (retire_cnt_q == LAST)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Tap LATENCY-1 marks the cycle the datapath output belongs to an issued row.
  assign vld_d = {vld_q[LATENCY-1:0], issue};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      issue_cnt_q  <= '0;
      retire_cnt_q <= '0;
      vld_q        <= '0;
      last_row_q   <= '0;
      res_data_q   <= '0;
      res_idx_q    <= '0;
    end else begin
      state_q      <= state_d;
      issue_cnt_q  <= issue_cnt_d;
      retire_cnt_q <= retire_cnt_d;
      vld_q        <= vld_d;
      last_row_q   <= last_row_d;
      if (vld_q[LATENCY-1]) begin
        res_data_q <= dp_out_data;
        res_idx_q  <= dp_out_id;
      end
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign row_idx   = issue ? issue_cnt_q[7:0] : last_row_q;
  assign dp_in_id  = row_idx;
  assign res_valid = vld_q[LATENCY];
  assign res_data  = res_data_q;
  assign res_idx   = res_idx_q;

`ifdef IP_BACKWARD_CTRL_ID_CHECK_EN
  logic start_acc;
  logic id_err_q, id_err_d;

  assign start_acc = (state_q == IDLE) && start;

  always_comb begin
    id_err_d = id_err_q;
    if (start_acc) id_err_d = 1'b0;
    else if (res_valid && (res_idx_q != retire_cnt_q[7:0])) id_err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) id_err_q <= 1'b0;
    else       id_err_q <= id_err_d;
  end

  assign id_err = id_err_q;
`else
  assign id_err = 1'b0;
`endif

endmodule

// File: tb/tb_ip_backward_ctrl.sv
// Bench for ip_backward_ctrl: instance 0 (NUM_OUT=4, LATENCY=5) and instance 1 (NUM_OUT=256, LATENCY=1).
module tb_ip_backward_ctrl;
  localparam int NA = 4, LA = 5, NB = 256, LB = 1;
  localparam bit F = 1'b0, T = 1'b1;
`ifdef IP_BACKWARD_CTRL_ID_CHECK_EN
  localparam bit IDCHK = 1'b1;
`else
  localparam bit IDCHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic [1:0] i_start, i_hold;
  logic [1:0][31:0] i_dpd;
  logic [1:0][7:0]  i_dpid;
  logic [1:0] o_busy, o_done, o_iss, o_rv, o_err;
  logic [1:0][7:0]  o_row, o_dpin, o_ridx;
  logic [1:0][31:0] o_rdat;

  always #5 clk = ~clk;

  ip_backward_ctrl #(.NUM_OUT(NA), .LATENCY(LA)) dut_a (
    .clk(clk), .reset(reset), .start(i_start[0]), .hold(i_hold[0]),
    .busy(o_busy[0]), .done(o_done[0]), .issue(o_iss[0]), .row_idx(o_row[0]),
    .dp_in_id(o_dpin[0]), .dp_out_data(i_dpd[0]), .dp_out_id(i_dpid[0]),
    .res_valid(o_rv[0]), .res_data(o_rdat[0]), .res_idx(o_ridx[0]), .id_err(o_err[0]));

  ip_backward_ctrl #(.NUM_OUT(NB), .LATENCY(LB)) dut_b (
    .clk(clk), .reset(reset), .start(i_start[1]), .hold(i_hold[1]),
    .busy(o_busy[1]), .done(o_done[1]), .issue(o_iss[1]), .row_idx(o_row[1]),
    .dp_in_id(o_dpin[1]), .dp_out_data(i_dpd[1]), .dp_out_id(i_dpid[1]),
    .res_valid(o_rv[1]), .res_data(o_rdat[1]), .res_idx(o_ridx[1]), .id_err(o_err[1]));

  int vec = 0, fails = 0, cyc = 0;
  int cnt_rv[2], cnt_done[2], cnt_iss[2];

  // Reference model: a pass is "active" from the accepted start until its done cycle.
  bit        m_act[2];
  int        m_iss[2], m_ret[2], m_done_at[2], cor_seq[2];
  logic [7:0] m_last[2];
  bit        m_err[2];
  bit        pr_v[2];
  logic [7:0] pr_id[2];
  logic [31:0] pr_dat[2];
  int        pr_seq[2];
  // Fake datapath: results scheduled by absolute cycle modulo 128.
  bit        s_v[2][128];
  logic [7:0] s_id[2][128];
  logic [31:0] s_dat[2][128];
  int        s_seq[2][128];

  task automatic chk(input int k, input string name, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s inst%0d cycle %0d: got %h expected %h", name, k, cyc, act, exp);
    end
  endtask

  task automatic step_model(input int k, input bit r, input bit st, input bit hd);
    int n = (k != 0) ? NB : NA;
    int l = (k != 0) ? LB : LA;
    int slot = cyc % 128;
    bit e_iss, e_done;
    logic [7:0] e_row;
    if (r) begin
      chk(k, "rst_busy", 32'(o_busy[k]), 0);  chk(k, "rst_done", 32'(o_done[k]), 0);
      chk(k, "rst_issue", 32'(o_iss[k]), 0);  chk(k, "rst_rv", 32'(o_rv[k]), 0);
      chk(k, "rst_err", 32'(o_err[k]), 0);    chk(k, "rst_row", 32'(o_row[k]), 0);
      chk(k, "rst_dpin", 32'(o_dpin[k]), 0);  chk(k, "rst_ridx", 32'(o_ridx[k]), 0);
      chk(k, "rst_rdat", o_rdat[k], 0);
      m_act[k] = 0; m_last[k] = '0; m_err[k] = 0; pr_v[k] = 0;
      for (int j = 0; j < 128; j++) s_v[k][j] = 0;
      return;
    end
    e_iss  = m_act[k] && (m_iss[k] < n) && !hd;
    e_row  = e_iss ? 8'(m_iss[k]) : m_last[k];
    e_done = m_act[k] && (cyc == m_done_at[k]);
    chk(k, "busy", 32'(o_busy[k]), 32'(m_act[k]));
    chk(k, "done", 32'(o_done[k]), 32'(e_done));
    chk(k, "issue", 32'(o_iss[k]), 32'(e_iss));
    chk(k, "row_idx", 32'(o_row[k]), 32'(e_row));
    chk(k, "dp_in_id", 32'(o_dpin[k]), 32'(e_row));
    chk(k, "res_valid", 32'(o_rv[k]), 32'(pr_v[k]));
    chk(k, "id_err", 32'(o_err[k]), 32'(m_err[k]));
    if (pr_v[k]) begin
      chk(k, "res_idx", 32'(o_ridx[k]), 32'(pr_id[k]));
      chk(k, "res_data", o_rdat[k], pr_dat[k]);
      if (IDCHK && (pr_id[k] != 8'(pr_seq[k]))) m_err[k] = 1;
      m_ret[k]++;
      if (m_ret[k] == n) m_done_at[k] = cyc + 1;
    end
    pr_v[k] = s_v[k][slot];
    pr_id[k] = s_id[k][slot]; pr_dat[k] = s_dat[k][slot]; pr_seq[k] = s_seq[k][slot];
    s_v[k][slot] = 0;
    if (e_iss) begin
      s_v[k][(cyc + l) % 128]   = 1;
      s_id[k][(cyc + l) % 128]  = (m_iss[k] == cor_seq[k]) ? 8'h02 : 8'(m_iss[k]);
      s_seq[k][(cyc + l) % 128] = m_iss[k];
      s_dat[k][(cyc + l) % 128] = $urandom;
      m_last[k] = 8'(m_iss[k]);
      m_iss[k]++;
    end
    if (e_done) m_act[k] = 0;
    else if (!m_act[k] && st) begin
      m_act[k] = 1; m_iss[k] = 0; m_ret[k] = 0; m_done_at[k] = -1; m_err[k] = 0;
    end
  endtask

  task automatic cyc_step(input bit r, input bit sa, input bit ha, input bit sb, input bit hb);
    @(negedge clk);
    reset = r; i_start = {sb, sa}; i_hold = {hb, ha};
    for (int k = 0; k < 2; k++) begin
      if (s_v[k][cyc % 128]) begin
        i_dpd[k] = s_dat[k][cyc % 128]; i_dpid[k] = s_id[k][cyc % 128];
      end else begin
        i_dpd[k] = $urandom; i_dpid[k] = 8'($urandom);
      end
    end
    #1;
    step_model(0, r, sa, ha);
    step_model(1, r, sb, hb);
    for (int k = 0; k < 2; k++) begin
      if (o_rv[k]) cnt_rv[k]++;
      if (o_done[k]) cnt_done[k]++;
      if (o_iss[k]) cnt_iss[k]++;
    end
    cyc++;
  endtask

  typedef struct {
    bit st; bit hd; bit busy; bit done; bit iss; logic [7:0] row; bit rv; logic [7:0] ridx;
  } vec_t;
  vec_t tbl[28];

  initial begin
    tbl[0]  = '{T,F, F,F,F,8'd0, F,8'd0};
    tbl[1]  = '{F,F, T,F,T,8'd0, F,8'd0};
    tbl[2]  = '{F,F, T,F,T,8'd1, F,8'd0};
    tbl[3]  = '{F,F, T,F,T,8'd2, F,8'd0};
    tbl[4]  = '{F,F, T,F,T,8'd3, F,8'd0};
    tbl[5]  = '{F,F, T,F,F,8'd3, F,8'd0};
    tbl[6]  = '{F,F, T,F,F,8'd3, F,8'd0};
    tbl[7]  = '{F,F, T,F,F,8'd3, T,8'd0};
    tbl[8]  = '{F,F, T,F,F,8'd3, T,8'd1};
    tbl[9]  = '{F,F, T,F,F,8'd3, T,8'd2};
    tbl[10] = '{F,F, T,F,F,8'd3, T,8'd3};
    tbl[11] = '{F,F, T,T,F,8'd3, F,8'd0};
    tbl[12] = '{F,F, F,F,F,8'd3, F,8'd0};
    tbl[13] = '{T,F, F,F,F,8'd3, F,8'd0};
    tbl[14] = '{F,F, T,F,T,8'd0, F,8'd0};
    tbl[15] = '{F,T, T,F,F,8'd0, F,8'd0};
    tbl[16] = '{F,T, T,F,F,8'd0, F,8'd0};
    tbl[17] = '{F,F, T,F,T,8'd1, F,8'd0};
    tbl[18] = '{F,F, T,F,T,8'd2, F,8'd0};
    tbl[19] = '{F,F, T,F,T,8'd3, F,8'd0};
    tbl[20] = '{F,F, T,F,F,8'd3, T,8'd0};
    tbl[21] = '{F,F, T,F,F,8'd3, F,8'd0};
    tbl[22] = '{F,F, T,F,F,8'd3, F,8'd0};
    tbl[23] = '{F,F, T,F,F,8'd3, T,8'd1};
    tbl[24] = '{F,F, T,F,F,8'd3, T,8'd2};
    tbl[25] = '{F,F, T,F,F,8'd3, T,8'd3};
    tbl[26] = '{F,F, T,T,F,8'd3, F,8'd0};
    tbl[27] = '{F,F, F,F,F,8'd3, F,8'd0};

    reset = 1'b1; i_start = '0; i_hold = '0; i_dpd = '0; i_dpid = '0;
    for (int k = 0; k < 2; k++) begin
      m_act[k] = 0; m_iss[k] = 0; m_ret[k] = 0; m_done_at[k] = -1; cor_seq[k] = -1;
      m_last[k] = '0; m_err[k] = 0; pr_v[k] = 0;
      cnt_rv[k] = 0; cnt_done[k] = 0; cnt_iss[k] = 0;
      for (int j = 0; j < 128; j++) s_v[k][j] = 0;
    end
    cyc_step(1, 0, 0, 0, 0);
    cyc_step(1, 0, 0, 0, 0);
    cyc_step(0, 0, 0, 0, 0);

    // Basic pass followed by a pass with hold gaps.
    for (int i = 0; i < 28; i++) begin
      cyc_step(0, tbl[i].st, tbl[i].hd, 0, 0);
      chk(0, "tbl_busy", 32'(o_busy[0]), 32'(tbl[i].busy));
      chk(0, "tbl_done", 32'(o_done[0]), 32'(tbl[i].done));
      chk(0, "tbl_issue", 32'(o_iss[0]), 32'(tbl[i].iss));
      chk(0, "tbl_row", 32'(o_row[0]), 32'(tbl[i].row));
      chk(0, "tbl_rv", 32'(o_rv[0]), 32'(tbl[i].rv));
      if (tbl[i].rv) chk(0, "tbl_ridx", 32'(o_ridx[0]), 32'(tbl[i].ridx));
    end

    // Start re-pulsed while busy, including in the done cycle.
    cnt_rv[0] = 0; cnt_done[0] = 0;
    for (int r = 0; r < 16; r++) cyc_step(0, (r == 0 || r == 3 || r == 11), 0, 0, 0);
    chk(0, "repulse_rv_count", 32'(cnt_rv[0]), 4);
    chk(0, "repulse_done_count", 32'(cnt_done[0]), 1);

    // Corrupted id on the second result, cleared by the next accepted start.
    cor_seq[0] = 1;
    for (int r = 0; r < 16; r++) begin
      cyc_step(0, (r == 0), 0, 0, 0);
      if (r == 9) chk(0, "id_err_set", 32'(o_err[0]), 32'(IDCHK));
    end
    cor_seq[0] = -1;
    chk(0, "id_err_sticky", 32'(o_err[0]), 32'(IDCHK));
    cyc_step(0, 1, 0, 0, 0);
    cyc_step(0, 0, 0, 0, 0);
    chk(0, "id_err_cleared", 32'(o_err[0]), 0);
    for (int r = 0; r < 14; r++) cyc_step(0, 0, 0, 0, 0);

    // Reset mid-pass, start on the release cycle.
    for (int r = 0; r < 28; r++) begin
      if (r == 5) cnt_rv[0] = 0;
      cyc_step((r == 5 || r == 6), (r == 0 || r == 7), 0, 0, 0);
      if (r == 13) chk(0, "no_stale_rv", 32'(cnt_rv[0]), 0);
    end

    // Full 256-row pass at minimum latency.
    cnt_rv[1] = 0; cnt_done[1] = 0; cnt_iss[1] = 0;
    for (int r = 0; r < 262; r++) cyc_step(0, 0, 0, (r == 0), 0);
    chk(1, "n256_issues", 32'(cnt_iss[1]), 256);
    chk(1, "n256_results", 32'(cnt_rv[1]), 256);
    chk(1, "n256_done", 32'(cnt_done[1]), 1);

    // Randomized traffic against the model.
    for (int r = 0; r < 700; r++)
      cyc_step(($urandom % 250) == 0, ($urandom % 8) == 0, ($urandom % 3) == 0,
               ($urandom % 64) == 0, ($urandom % 4) == 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, fails);
    $finish;
  end
endmodule

// File: doc/ip_backward_ctrl.md
IP_BACKWARD_CTRL -- requirements
Module: ip_backward_ctrl

Interface
REQ-001 SHALL have parameter NUM_OUT, default 16, number of output rows (dot products) per pass, range 1..256.
REQ-002 SHALL have parameter LATENCY, default 20, cycles from datapath input sample to matching out_data/out_id at datapath output, range 1..64.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  pulse; begins one pass when sampled high in IDLE.
REQ-006 SHALL have port hold  input  1  row source not ready; suppresses issue this cycle.
REQ-007 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-008 SHALL have port done  output  1  one-cycle pulse at pass completion.
REQ-009 SHALL have port issue  output  1  datapath inputs (in_data, weights row row_idx, bias) valid this cycle.
REQ-010 SHALL have port row_idx  output  8  row being issued; selects weight row and bias.
REQ-011 SHALL have port dp_in_id  output  8  id driven to datapath in_id; equals row_idx.
REQ-012 SHALL have port dp_out_data  input  32  datapath out_data, IEEE-754 single.
REQ-013 SHALL have port dp_out_id  input  8  datapath out_id.
REQ-014 SHALL have port res_valid  output  1  res_data/res_idx valid this cycle.
REQ-015 SHALL have port res_data  output  32  captured dot-product result.
REQ-016 SHALL have port res_idx  output  8  row index of res_data.
REQ-017 SHALL have port id_err  output  1  sticky id-mismatch flag (present only per REQ-033).

Function
REQ-018 SHALL implement states IDLE, ISSUE, DRAIN, DONE.
REQ-019 IDLE->ISSUE SHALL occur on the edge where start=1; issue/row counters SHALL clear to 0 on that edge.
REQ-020 In ISSUE, issue SHALL equal !hold; each cycle with issue=1 SHALL present row_idx=issue_cnt, then issue_cnt increments.
REQ-021 ISSUE->DRAIN SHALL occur on the edge at which issue_cnt reaches NUM_OUT; hold in ISSUE SHALL only insert gaps, never reorder or drop rows.
REQ-022 A LATENCY+1 deep valid shift register SHALL track in-flight issues; its final tap SHALL drive res_valid; res_data/res_idx SHALL register dp_out_data/dp_out_id on the same edge (result for issue at cycle c valid at cycle c+LATENCY+1).
REQ-023 retire_cnt SHALL increment per res_valid; DRAIN->DONE SHALL occur on the edge where the NUM_OUT-th result retires.
REQ-024 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-025 start SHALL be ignored whenever busy=1; start and last retire in the same cycle SHALL not start a new pass.
REQ-026 issue SHALL be 0 in IDLE, DRAIN, DONE; row_idx SHALL hold its last value when issue=0.
REQ-027 NUM_OUT=1 SHALL yield a single issue then DRAIN; no wrap of 8-bit counters SHALL occur for NUM_OUT=256 (counters 9 bits internally).

Reset
REQ-028 reset SHALL asynchronously force state IDLE, all counters and the valid shift register to 0.
REQ-029 During reset, busy, done, issue, res_valid, id_err SHALL be 0; row_idx, dp_in_id, res_idx SHALL be 0; res_data SHALL be 32'h0.
REQ-030 Reset mid-pass SHALL discard all in-flight results; no res_valid SHALL appear after reset deasserts until a new pass issues.
REQ-031 After reset deasserts, the first start SHALL be honoured on the first edge.

Configuration
REQ-032 Macro IP_BACKWARD_CTRL_ID_CHECK_EN SHALL compile in id checking.
REQ-033 With it defined: on each res_valid, if dp_out_id != expected retire_cnt[7:0], id_err SHALL set and stay high until reset or next accepted start; without it, id_err SHALL be tied 0 and no compare logic built.

Verification
REQ-034 NUM_OUT=4, LATENCY=5, start at cycle 0, hold=0 -> issue cycles 1..4 ids 0..3; res_valid cycles 7..10 idx 0..3; done cycle 11; busy cycles 1..11.
REQ-035 Same, hold=1 on cycles 2-3 -> issues at cycles 1,4,5,6 ids 0,1,2,3; res_valid cycles 7,10,11,12; done cycle 13.
REQ-036 reset asserted at cycle 5 of REQ-034 pass, released at cycle 7 -> all outputs 0 immediately; no res_valid through cycle 20; new start accepted at cycle 7.
REQ-037 start re-pulsed at cycles 3 and 11 of REQ-034 pass -> ignored; exactly 4 res_valid, one done.
REQ-038 With ID_CHECK_EN, dp_out_id forced to 8'h02 on the second result -> id_err=1 from cycle 9, stays 1 until next start; without macro id_err=0.
REQ-039 NUM_OUT=256, LATENCY=1 -> 256 contiguous issues idx 0..255, 256 results, single done, no counter wrap.
